// File: rtl/fetch_stage.sv
// Fetch stage: PC register, ROM address generation and IF/ID pipeline register.
// Handles stall, flush and branch redirect, and halts with a sticky fault on a bad fetch.
module fetch_stage #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      IMEM_BYTES = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic [WIDTH-1:0] if_id_instr_o,
    output logic [WIDTH-1:0] if_id_pc_o,
    output logic [WIDTH-1:0] if_id_pc_plus4_o,
    output logic             if_id_valid_o,
    output logic             fault_o,
    output logic [1:0]       fault_cause_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10
    } cause_e;

    localparam int unsigned   XW         = WIDTH + 1;
    localparam logic [XW-1:0] IMEM_LIMIT = XW'(IMEM_BYTES);

    // One extra bit so an address that wraps past 2^WIDTH reads as out of range.
    function automatic logic fetch_ok(input logic [WIDTH-1:0] addr, input logic [XW-1:0] span);
        return ({1'b0, addr} + span) < IMEM_LIMIT;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic [WIDTH-1:0] id_pc4_q, id_pc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    cause_e           cause_q, cause_d;

    logic [WIDTH-1:0] pc_plus4;
    logic             seq_ok;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign seq_ok   = fetch_ok(pc_q, XW'(7));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        cause_d  = cause_q;

        unique case (state_q)
            BOOT: begin
                if (fetch_ok(pc_q, XW'(3))) begin
                    state_d = RUN;
                end else begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_RANGE;
                end
            end

            RUN: begin
                if (branch_taken_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (branch_target_i[1:0] != 2'b00) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else if (!fetch_ok(branch_target_i, XW'(3))) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_RANGE;
                    end else begin
                        pc_d = branch_target_i;
                    end
                end else if (flush_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (!stall_i) begin
                        if (seq_ok) begin
                            pc_d = pc_plus4;
                        end else begin
                            state_d = HALT;
                            fault_d = 1'b1;
                            cause_d = CAUSE_RANGE;
                        end
                    end
                end else if (!stall_i) begin
                    // The current word is still captured even when the next PC would fault.
                    instr_d  = imem_rdata_i;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_plus4;
                    valid_d  = 1'b1;
                    if (seq_ok) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_RANGE;
                    end
                end
            end

            HALT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            id_pc_q  <= '0;
            id_pc4_q <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    assign imem_addr_o      = pc_q;
    assign if_id_instr_o    = instr_q;
    assign if_id_pc_o       = id_pc_q;
    assign if_id_pc_plus4_o = id_pc4_q;
    assign if_id_valid_o    = valid_q;
    assign fault_o          = fault_q;
    assign fault_cause_o    = cause_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main run, hand sequences for
// asynchronous reset, misaligned and out-of-range branch faults.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (32),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc_plus4_o (if_id_pc_plus4_o),
        .if_id_valid_o    (if_id_valid_o),
        .fault_o          (fault_o),
        .fault_cause_o    (fault_cause_o)
    );

    // 32-byte ROM, big-endian within a word.
    logic [7:0] rom [0:31];
    initial begin
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h13;
        rom[4] = 8'h00; rom[5] = 8'h10; rom[6] = 8'h00; rom[7] = 8'h93;
        for (int i = 8; i < 32; i++) rom[i] = 8'(8'h40 + i);
    end
    assign imem_rdata_i = (imem_addr_o <= 32'd28) ?
        {rom[imem_addr_o[4:0]], rom[imem_addr_o[4:0] + 5'd1],
         rom[imem_addr_o[4:0] + 5'd2], rom[imem_addr_o[4:0] + 5'd3]} : 32'h0;

    typedef struct {
        logic        stall, flush, br;
        logic [31:0] tgt;
        logic [31:0] instr, pc, pc4;
        logic        valid, chk_pc;
        logic [31:0] addr;
        logic        fault;
        logic [1:0]  cause;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                                input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4,
                                input logic v, input logic c, input logic [31:0] addr,
                                input logic flt, input logic [1:0] cause);
        vec_t r;
        r.stall = s; r.flush = f; r.br = b; r.tgt = t;
        r.instr = instr; r.pc = pc; r.pc4 = pc4; r.valid = v; r.chk_pc = c;
        r.addr = addr; r.fault = flt; r.cause = cause;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
        stall_i = s; flush_i = f; branch_taken_i = b; branch_target_i = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input vec_t v);
        chk({tag, ".addr"},  imem_addr_o, v.addr);
        chk({tag, ".instr"}, if_id_instr_o, v.instr);
        chk({tag, ".valid"}, {31'b0, if_id_valid_o}, {31'b0, v.valid});
        chk({tag, ".fault"}, {31'b0, fault_o}, {31'b0, v.fault});
        chk({tag, ".cause"}, {30'b0, fault_cause_o}, {30'b0, v.cause});
        if (v.chk_pc) begin
            chk({tag, ".pc"},  if_id_pc_o, v.pc);
            chk({tag, ".pc4"}, if_id_pc_plus4_o, v.pc4);
        end
    endtask

    task automatic run_row(input string tag, input vec_t v);
        step(v.stall, v.flush, v.br, v.tgt);
        check_row(tag, v);
    endtask

    task automatic chk_reset(input string tag);
        check_row(tag, mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 1, 0, 0, 2'b00));
    endtask

    // Asserts rst away from any clock edge, checks immediately, releases on a falling edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 chk_reset(tag);
        stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [16];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 0, 0, 32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 1, 32'h00, 0, 2'b00);
        vecs[1]  = mk(0, 0, 0, 32'h00, 32'h0000_0013, 32'h00, 32'h04, 1, 1, 32'h04, 0, 2'b00);
        vecs[2]  = mk(0, 0, 0, 32'h00, 32'h0010_0093, 32'h04, 32'h08, 1, 1, 32'h08, 0, 2'b00);
        vecs[3]  = mk(1, 0, 0, 32'h00, 32'h0010_0093, 32'h04, 32'h08, 1, 1, 32'h08, 0, 2'b00);
        vecs[4]  = mk(1, 0, 0, 32'h00, 32'h0010_0093, 32'h04, 32'h08, 1, 1, 32'h08, 0, 2'b00);
        vecs[5]  = mk(1, 0, 0, 32'h00, 32'h0010_0093, 32'h04, 32'h08, 1, 1, 32'h08, 0, 2'b00);
        vecs[6]  = mk(0, 0, 0, 32'h00, 32'h4849_4A4B, 32'h08, 32'h0C, 1, 1, 32'h0C, 0, 2'b00);
        vecs[7]  = mk(1, 0, 1, 32'h10, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h10, 0, 2'b00);
        vecs[8]  = mk(0, 0, 0, 32'h00, 32'h5051_5253, 32'h10, 32'h14, 1, 1, 32'h14, 0, 2'b00);
        vecs[9]  = mk(1, 1, 0, 32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h14, 0, 2'b00);
        vecs[10] = mk(0, 1, 0, 32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h18, 0, 2'b00);
        vecs[11] = mk(0, 0, 0, 32'h00, 32'h5859_5A5B, 32'h18, 32'h1C, 1, 1, 32'h1C, 0, 2'b00);
        vecs[12] = mk(0, 0, 0, 32'h00, 32'h5C5D_5E5F, 32'h1C, 32'h20, 1, 1, 32'h1C, 1, 2'b10);
        vecs[13] = mk(0, 0, 0, 32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h1C, 1, 2'b10);
        vecs[14] = mk(0, 1, 1, 32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h1C, 1, 2'b10);
        vecs[15] = mk(1, 0, 1, 32'h08, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 32'h1C, 1, 2'b10);

        #12 chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_row($sformatf("vec%0d", i), vecs[i]);

        // Reset must be the only way out of HALT.
        async_reset("rst_from_halt");
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("run_pc8.addr", imem_addr_o, 32'h08);
        async_reset("rst_mid_run");
        step(0, 0, 0, 0);
        check_row("boot", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 1, 32'h00, 0, 2'b00));
        step(0, 0, 0, 0);
        check_row("resume", mk(0, 0, 0, 0, 32'h13, 32'h00, 32'h04, 1, 1, 32'h04, 0, 2'b00));

        step(0, 0, 1, 32'h06);
        check_row("br_mis", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h04, 1, 2'b01));
        step(0, 0, 1, 32'h08);
        check_row("mis_hold1", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h04, 1, 2'b01));
        step(1, 1, 0, 0);
        check_row("mis_hold2", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h04, 1, 2'b01));

        async_reset("rst_from_mis");
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1C);
        check_row("br_last", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h1C, 0, 2'b00));
        step(0, 0, 1, 32'h20);
        check_row("br_oor", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h1C, 1, 2'b10));
        step(0, 0, 0, 0);
        check_row("oor_hold", mk(0, 0, 0, 0, 32'h13, 0, 0, 0, 0, 32'h1C, 1, 2'b10));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
